// File: rtl/pulse_gen_mc.sv
// Multi-channel single-pulse generator with prescaled delay/width counters.
// Optional PULSE_RETRIG_EN: edge-mode rising edge in ACTIVE restarts the width.
module pulse_gen_mc #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 17,
  parameter int DIV_W = 20
) (
  input  logic                   clk_Pulse,
  input  logic                   rst_Pulse,
  input  logic [N_CH-1:0]        trig,
  input  logic [N_CH-1:0]        cfg_mode,
  input  logic [N_CH*DIV_W-1:0]  cfg_presc,
  input  logic [N_CH*CNT_W-1:0]  cfg_delay,
  input  logic [N_CH*CNT_W-1:0]  cfg_width,
  output logic [N_CH-1:0]        pl_out,
  output logic [N_CH-1:0]        launch_DL,
  output logic [N_CH-1:0]        busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]       state;
    logic             mode;
    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] pcnt;
    logic [CNT_W-1:0] dly;
    logic [CNT_W-1:0] wid;
    logic [CNT_W-1:0] tcnt;
    logic [CNT_W:0]   tinc;
    logic             prev;
    logic             pl;
    logic             launch;
    logic             rise;
    logic             accept;
    logic             tick;
    logic             abort;

    assign rise   = trig[i] & ~prev;
    assign accept = cfg_mode[i] ? rise : trig[i];
    assign tick   = (pcnt == presc);
    assign abort  = ~mode & ~trig[i];
    // one bit wider so a count reaching the maximum value cannot wrap
    assign tinc   = {1'b0, tcnt} + {{CNT_W{1'b0}}, 1'b1};

    assign pl_out[i]    = pl;
    assign launch_DL[i] = launch;
    assign busy[i]      = (state == DELAY) || (state == ACTIVE);

    always_ff @(posedge clk_Pulse or posedge rst_Pulse) begin
      if (rst_Pulse) begin
        state  <= IDLE;
        mode   <= 1'b0;
        presc  <= '0;
        pcnt   <= '0;
        dly    <= '0;
        wid    <= '0;
        tcnt   <= '0;
        prev   <= 1'b0;
        pl     <= 1'b0;
        launch <= 1'b0;
      end else begin
        prev <= trig[i];
        unique case (state)
          IDLE: begin
            pl     <= 1'b0;
            launch <= 1'b0;
            if (accept) begin
              mode  <= cfg_mode[i];
              presc <= cfg_presc[i*DIV_W +: DIV_W];
              dly   <= cfg_delay[i*CNT_W +: CNT_W];
              wid   <= cfg_width[i*CNT_W +: CNT_W];
              pcnt  <= '0;
              tcnt  <= '0;
              if (cfg_delay[i*CNT_W +: CNT_W] != '0) begin
                state <= DELAY;
              end else if (cfg_width[i*CNT_W +: CNT_W] != '0) begin
                state <= ACTIVE;
                pl    <= 1'b1;
              end else begin
                state  <= DONE;
                launch <= 1'b1;
              end
            end
          end
          DELAY: begin
            if (abort) begin
              state <= IDLE;
            end else begin
              pcnt <= tick ? '0 : pcnt + {{(DIV_W-1){1'b0}}, 1'b1};
              if (tick) begin
                if (tinc == {1'b0, dly}) begin
                  tcnt <= '0;
                  if (wid != '0) begin
                    state <= ACTIVE;
                    pl    <= 1'b1;
                  end else begin
                    state  <= DONE;
                    launch <= 1'b1;
                  end
                end else begin
                  tcnt <= tinc[CNT_W-1:0];
                end
              end
            end
          end
          ACTIVE: begin
            if (abort) begin
              state <= IDLE;
              pl    <= 1'b0;
`ifdef PULSE_RETRIG_EN
            end else if (mode && rise) begin
              pcnt <= '0;
              tcnt <= '0;
`endif
            end else begin
              pcnt <= tick ? '0 : pcnt + {{(DIV_W-1){1'b0}}, 1'b1};
              if (tick) begin
                if (tinc == {1'b0, wid}) begin
                  state  <= DONE;
                  pl     <= 1'b0;
                  launch <= 1'b1;
                end else begin
                  tcnt <= tinc[CNT_W-1:0];
                end
              end
            end
          end
          DONE: begin
            // edge mode: single-cycle flag; level mode: hold until trig drops
            if (mode || !trig[i]) begin
              state  <= IDLE;
              launch <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pulse_gen_mc.md
Name: pulse_gen_mc

Overview:
- Multi-channel programmable single-pulse generator for the trigger/delay chain.
- Each of N_CH channels produces one delayed pulse per trigger: programmable delay and width, counted in per-channel prescaled ticks.
- Each channel runs in level-hold mode or edge-launch mode and raises a completion flag that drives the downstream delay-line launch.
- No derived clocks: prescaling is a clock enable in the single clk_Pulse domain.

Parameters:
- N_CH, 4, number of independent channels (1..16)
- CNT_W, 17, width of the delay and width counters, in ticks
- DIV_W, 20, width of the per-channel prescaler; tick period = presc+1 clk_Pulse cycles

Ports:
- clk_Pulse  in  1  system clock, all logic on rising edge
- rst_Pulse  in  1  asynchronous, active-high reset
- trig  in  N_CH  per-channel trigger, synchronous to clk_Pulse
- cfg_mode  in  N_CH  per channel: 0 = level-hold, 1 = edge-launch
- cfg_presc  in  N_CH*DIV_W  per-channel prescale value, channel i at [i*DIV_W +: DIV_W]
- cfg_delay  in  N_CH*CNT_W  delay in ticks, channel i at [i*CNT_W +: CNT_W]
- cfg_width  in  N_CH*CNT_W  pulse width in ticks, channel i at [i*CNT_W +: CNT_W]
- pl_out  out  N_CH  pulse outputs, registered
- launch_DL  out  N_CH  completion flags, registered
- busy  out  N_CH  high while a channel is in DELAY or ACTIVE

Behaviour:
- Reset (asynchronous, immediate):
  - pl_out, launch_DL, busy = 0.
  - All channels go to IDLE; counters, prescalers and trigger history are cleared.
  - Assertion mid-pulse drops pl_out with no completion flag.
- Channel FSM states: IDLE, DELAY, ACTIVE, DONE. Channels are fully independent.
- Trigger acceptance, on the clk_Pulse edge T, only when the channel is in IDLE:
  - Level mode: trig sampled 1.
  - Edge mode: trig sampled 1 and trig sampled 0 at edge T-1. Trigger history resets to 0, so trig held high through reset release counts as an edge.
- At acceptance:
  - cfg_mode, cfg_presc, cfg_delay and cfg_width are latched.
  - Config changes during a pulse are ignored until the next acceptance.
  - The prescaler and tick counter clear. Ticks occur every P = presc+1 cycles, counted from T.
- Next state at acceptance: DELAY if delay > 0; ACTIVE if delay = 0 and width > 0; DONE if both are 0.
- Timing, with D = delay and W = width:
  - pl_out rises at edge T + D*P and falls at edge T + (D+W)*P.
  - busy = 1 from T until pl_out falls; for D = W = 0, busy stays 0.
  - W = 0 with D > 0: busy for D*P cycles, then DONE, with no pl_out.
  - Counters compare in CNT_W bits; maximum values must not wrap.
- DONE, level mode:
  - launch_DL = 1 and is held while trig = 1.
  - trig = 0 gives IDLE with launch_DL = 0 at the next edge.
  - Retriggering needs trig low for at least one cycle.
- DONE, edge mode:
  - launch_DL is a 1-cycle pulse on the edge where pl_out falls, or at T for D = W = 0.
  - The channel returns to IDLE on the following edge.
  - An edge in that same cycle is ignored.
- Abort (level mode only): trig = 0 sampled in DELAY or ACTIVE gives IDLE at that edge; pl_out = 0, launch_DL is not asserted, busy = 0.
- Edge mode while busy: further rising edges are ignored (unless PULSE_RETRIG_EN).
- Simultaneous width expiry and level-mode trig drop: the abort wins, so no launch_DL.

Optional Feature:
- Macro: PULSE_RETRIG_EN.
- When defined, in edge mode a rising edge of trig during ACTIVE restarts the width count:
  - pl_out stays high and falls W*P cycles after that edge.
  - The prescaler re-phases to that edge; config is not re-latched.
- A rising edge during DELAY is still ignored.
- When undefined, rising edges in DELAY and ACTIVE are both ignored.

Test Plan:
- Reset, then ch0 edge mode, presc=0, D=3, W=5, 1-cycle trig at edge 10 -> pl_out[0] high edges 13..17, falls at 18; launch_DL[0] pulses at 18; busy 10..17.
- ch1 level mode, presc=9, D=2, W=4, trig held -> pl_out rises T+20, falls T+60; launch_DL held until trig drops, clears next edge.
- ch1 level mode, trig dropped at T+30 -> pl_out 0 at T+30, launch_DL never asserts, busy 0.
- ch2 edge mode, D=W=0 -> no pl_out, launch_DL 1-cycle pulse at T; repeated edges during busy on ch0 ignored.
- All channels triggered on the same edge with different config, rst_Pulse asserted mid-pulse -> independent pulse timing; all outputs 0 immediately on reset.
- PULSE_RETRIG_EN, ch0 presc=0, W=5, second edge at T+3 -> pl_out falls at T+8, with a single launch_DL.
